// File: rtl/regfile_mp.sv
// Parametrised NUM_RD-read / 1-write register file with post-reset clear sequencer,
// same-cycle write forwarding and zero register. Optional pending-write scoreboard: RF_SCOREBOARD_EN.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     rsv_en_i,
  input  logic [ADDR_W-1:0]        rsv_addr_i,
  output logic [NUM_RD-1:0]        rd_pend_o,
  output logic                     ready_o
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_waddr_s;
  logic [DATA_W-1:0]   mem_wdata_s;

  logic [ADDR_W-1:0]   rd_addr_s [NUM_RD];
  logic [NUM_RD-1:0]   fwd_s;
  logic [NUM_RD*DATA_W-1:0] rd_data_s;

  // State register: clear sequencer position and ready flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Next-state: walk every entry once, then stay in RUN until reset
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Outputs of the FSM: the single storage write port is shared by clear and writeback
  always_comb begin
    ready_d     = (state_d == ST_RUN);
    mem_we_s    = 1'b0;
    mem_waddr_s = '0;
    mem_wdata_s = '0;
    case (state_q)
      ST_INIT: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = cnt_q;
        mem_wdata_s = '0;
      end
      ST_RUN: begin
        mem_we_s    = wr_en_i && (wr_addr_i != '0);
        mem_waddr_s = wr_addr_i;
        mem_wdata_s = wr_data_i;
      end
      default: begin
        mem_we_s    = 1'b0;
        mem_waddr_s = '0;
        mem_wdata_s = '0;
      end
    endcase
  end

  // Storage array; no reset, contents are wiped by the clear sequencer
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Per-port address decode and forward detection (address 0 never forwards)
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_addr_s[k] = rd_addr_i[k*ADDR_W +: ADDR_W];
      fwd_s[k]     = wr_en_i && (wr_addr_i == rd_addr_s[k]) && (rd_addr_s[k] != '0);
    end
  end

  // Read mux: zero register, then forwarded write data, then stored entry
  always_comb begin
    rd_data_s = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (state_q != ST_RUN || rd_addr_s[k] == '0) begin
        rd_data_s[k*DATA_W +: DATA_W] = '0;
      end else if (fwd_s[k]) begin
        rd_data_s[k*DATA_W +: DATA_W] = wr_data_i;
      end else begin
        rd_data_s[k*DATA_W +: DATA_W] = mem_q[rd_addr_s[k]];
      end
    end
  end

  assign rd_data_o = rd_data_s;
  assign ready_o   = ready_q;

`ifdef RF_SCOREBOARD_EN
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [NUM_RD-1:0] rd_pend_s;

  // Pending-bit storage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Writes retire a pending bit; a same-edge reserve of that address re-arms it
  always_comb begin
    pend_d = pend_q;
    if (state_q == ST_RUN) begin
      if (wr_en_i) begin
        pend_d[wr_addr_i] = 1'b0;
      end else begin
        pend_d = pend_d;
      end
      if (rsv_en_i && (rsv_addr_i != '0)) begin
        pend_d[rsv_addr_i] = 1'b1;
      end else begin
        pend_d = pend_d;
      end
    end else begin
      pend_d = pend_q;
    end
    pend_d[0] = 1'b0;
  end

  // A forwarded read is already satisfied unless a new producer reserves it this cycle
  always_comb begin
    rd_pend_s = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (state_q == ST_RUN &&
          !(fwd_s[k] && !(rsv_en_i && (rsv_addr_i == rd_addr_s[k])))) begin
        rd_pend_s[k] = pend_q[rd_addr_s[k]];
      end else begin
        rd_pend_s[k] = 1'b0;
      end
    end
  end

  assign rd_pend_o = rd_pend_s;
`else
  logic unused_rsv_s;
  assign unused_rsv_s = ^{rsv_en_i, rsv_addr_i};
  assign rd_pend_o    = '0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters, 2 read ports).
module tb_regfile_mp;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [9:0]  rd_addr_i;
  logic [63:0] rd_data_o;
  logic        wr_en_i;
  logic [4:0]  wr_addr_i;
  logic [31:0] wr_data_i;
  logic        rsv_en_i;
  logic [4:0]  rsv_addr_i;
  logic [1:0]  rd_pend_o;
  logic        ready_o;

  int total = 0;
  int bad   = 0;
  int n;

  regfile_mp dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .rsv_en_i   (rsv_en_i),
    .rsv_addr_i (rsv_addr_i),
    .rd_pend_o  (rd_pend_o),
    .ready_o    (ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance one rising edge, leave inputs settled 1ns after it
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr_i = {a1, a0};
    #1;
  endtask

  initial begin
    rst_i = 1'b1; rd_addr_i = 10'd0; wr_en_i = 1'b0; wr_addr_i = 5'd0;
    wr_data_i = 32'd0; rsv_en_i = 1'b0; rsv_addr_i = 5'd0;
    #1;
    rd(5'd5, 5'd5);
    check_eq("rst_ready", {31'd0, ready_o}, 32'd0);
    check_eq("rst_data", rd_data_o[31:0], 32'd0);
    check_eq("rst_pend", {30'd0, rd_pend_o}, 32'd0);
    step(); step();
    rst_i = 1'b0;

    // clear sequence; write and reserve r3 around edge 3 must be ignored
    for (int i = 1; i <= 32; i++) begin
      step();
      check_eq($sformatf("init_ready_e%0d", i), {31'd0, ready_o}, {31'd0, (i == 32)});
      if (i == 2) begin
        wr_en_i = 1'b1; wr_addr_i = 5'd3; wr_data_i = 32'h000000AA;
        rsv_en_i = 1'b1; rsv_addr_i = 5'd3;
        rd(5'd3, 5'd3);
        check_eq("init_data_forced", rd_data_o[31:0], 32'd0);
      end
      if (i == 3) begin
        wr_en_i = 1'b0; rsv_en_i = 1'b0;
      end
    end

    for (int a = 1; a < 32; a++) begin
      rd(a[4:0], a[4:0]);
      check_eq($sformatf("clear_r%0d", a), rd_data_o[63:32] | rd_data_o[31:0], 32'd0);
    end
    rd(5'd3, 5'd3);
    check_eq("init_pend_r3", {30'd0, rd_pend_o}, 32'd0);

    // plain write then dual-port read
    wr_en_i = 1'b1; wr_addr_i = 5'd5; wr_data_i = 32'hDEADBEEF;
    step();
    wr_en_i = 1'b0;
    rd(5'd5, 5'd5);
    check_eq("wr_r5_p0", rd_data_o[31:0], 32'hDEADBEEF);
    check_eq("wr_r5_p1", rd_data_o[63:32], 32'hDEADBEEF);

    // forward into port0 before the edge; port1 sees the old r5
    wr_en_i = 1'b1; wr_addr_i = 5'd7; wr_data_i = 32'h12345678;
    rd(5'd7, 5'd5);
    check_eq("fwd_p0", rd_data_o[31:0], 32'h12345678);
    check_eq("fwd_p1_other", rd_data_o[63:32], 32'hDEADBEEF);
    step();
    wr_en_i = 1'b0;
    rd(5'd7, 5'd7);
    check_eq("fwd_stored", rd_data_o[63:32], 32'h12345678);

    // zero register never forwards and is never written
    wr_en_i = 1'b1; wr_addr_i = 5'd0; wr_data_i = 32'hFFFFFFFF;
    rd(5'd7, 5'd0);
    check_eq("zero_fwd_p1", rd_data_o[63:32], 32'd0);
    step();
    wr_en_i = 1'b0;
    rd(5'd0, 5'd0);
    check_eq("zero_after", rd_data_o[31:0], 32'd0);

`ifdef RF_SCOREBOARD_EN
    rsv_en_i = 1'b1; rsv_addr_i = 5'd4;
    step();
    rsv_en_i = 1'b0;
    rd(5'd4, 5'd4);
    check_eq("sb_rsv_r4", {30'd0, rd_pend_o}, 32'd3);
    rsv_en_i = 1'b1; rsv_addr_i = 5'd4;
    wr_en_i = 1'b1; wr_addr_i = 5'd4; wr_data_i = 32'h00000011;
    rd(5'd4, 5'd4);
    check_eq("sb_same_pend_now", {31'd0, rd_pend_o[0]}, 32'd1);
    check_eq("sb_same_data", rd_data_o[31:0], 32'h00000011);
    step();
    rsv_en_i = 1'b0;
    wr_data_i = 32'h00000099;
    rd(5'd4, 5'd4);
    check_eq("sb_wr_pend_now", {31'd0, rd_pend_o[0]}, 32'd0);
    check_eq("sb_wr_data", rd_data_o[31:0], 32'h00000099);
    step();
    wr_en_i = 1'b0;
    rd(5'd4, 5'd4);
    check_eq("sb_after_wr", {30'd0, rd_pend_o}, 32'd0);
`else
    rsv_en_i = 1'b1; rsv_addr_i = 5'd4;
    step();
    rsv_en_i = 1'b0;
    rd(5'd4, 5'd4);
    check_eq("nosb_pend", {30'd0, rd_pend_o}, 32'd0);
`endif

    // mid-run reset wipes contents through a full re-clear
    wr_en_i = 1'b1; wr_addr_i = 5'd9; wr_data_i = 32'h00000055;
    step();
    wr_en_i = 1'b0;
    rd(5'd9, 5'd5);
    check_eq("r9_written", rd_data_o[31:0], 32'h00000055);
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("midrst_ready", {31'd0, ready_o}, 32'd0);
    check_eq("midrst_data", rd_data_o[31:0], 32'd0);
    step(); step();
    rst_i = 1'b0;
    n = 0;
    while (!ready_o && n < 40) begin
      step();
      n++;
    end
    check_eq("reclear_edges", n, 32'd32);
    rd(5'd9, 5'd5);
    check_eq("reclear_r9", rd_data_o[31:0], 32'd0);
    check_eq("reclear_r5", rd_data_o[63:32], 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port register file for the CPU pipeline. Generalises the 2R/1W 32x32 file in width, depth and read-port count. Adds:
- a hardware clear sequencer after reset;
- write-to-read forwarding that respects the zero register;
- an optional pending-write scoreboard.

Sits between decode (read ports, reserve) and writeback (write port).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of read ports (1..4)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous active-high reset
rd_addr_i  input  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
rd_data_o  output  NUM_RD*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W]
wr_en_i  input  1  write enable
wr_addr_i  input  ADDR_W  write address
wr_data_i  input  DATA_W  write data
rsv_en_i  input  1  reserve enable; marks rsv_addr_i as pending (scoreboard only)
rsv_addr_i  input  ADDR_W  destination being reserved
rd_pend_o  output  NUM_RD  per-port pending flag for rd_addr_i (scoreboard only)
ready_o  output  1  high once the clear sequence has completed

Behaviour:
- One clock, clk_i. Reset rst_i is asynchronous, active-high.

Reset and FSM:
- While rst_i is high:
  - state=INIT, clear counter=0, ready_o=0;
  - all pending bits=0;
  - rd_data_o=0, rd_pend_o=0.
- INIT state:
  - each rising edge writes 0 to entry[counter], then counter+1;
  - the edge that clears entry DEPTH-1 moves the FSM to RUN and sets ready_o=1.
  - ready_o therefore rises on the DEPTH-th edge after rst_i deasserts: 32 edges at default.
- During INIT:
  - wr_en_i and rsv_en_i are ignored;
  - rd_data_o and rd_pend_o are forced to 0.
- RUN is terminal until the next reset.
- rst_i asserted mid-INIT or mid-RUN returns to INIT immediately; the clear restarts from entry 0.

Write (RUN):
- On a rising edge with wr_en_i=1 and wr_addr_i!=0, entry[wr_addr_i] <= wr_data_i.
- Entry 0 is never written and always reads 0.

Read (RUN, combinational, zero latency):
- Per port k:
  - if rd_addr_k==0: output 0;
  - else if wr_en_i=1 and wr_addr_i==rd_addr_k: output wr_data_i (same-cycle forward);
  - else: output entry[rd_addr_k].
- Forwarding with wr_addr_i=0 never occurs; an address-0 read returns 0 even when wr_en_i=1 and wr_data_i!=0.
- All ports are independent. Any number of ports may read the same address in one cycle.

Optional Feature:
RF_SCOREBOARD_EN
- Defined: a DEPTH-bit pending vector.
  - Rising edge, RUN state:
    - rsv_en_i=1 and rsv_addr_i!=0 sets pend[rsv_addr_i];
    - wr_en_i=1 clears pend[wr_addr_i].
  - Same address reserved and written on one edge: the set wins and the bit stays 1 (new producer).
  - pend[0] is constant 0.
  - rd_pend_o[k] = pend[rd_addr_k], except it is 0 when the port is being forwarded from the current write and no same-cycle reserve targets that address.
  - rd_pend_o[k]=0 during INIT.
- Not defined:
  - no pending storage;
  - rsv_en_i and rsv_addr_i are unused;
  - rd_pend_o is tied to 0.

Test Plan:
- Reset/clear: pulse rst_i 2 cycles, release -> ready_o=0 for 31 edges, ready_o=1 after edge 32. Then read addrs 1..31 -> all return 0.
- Write/read: write 0xDEADBEEF to r5. Next cycle port0=5, port1=5 -> both 0xDEADBEEF.
- Forward and zero register:
  - wr_en_i=1, wr_addr_i=7, wr_data_i=0x12345678, port0 addr=7 in the same cycle -> port0=0x12345678 before the edge.
  - wr_addr_i=0, wr_data_i=0xFFFFFFFF, port1 addr=0 -> port1=0, and r0 still reads 0 afterwards.
- Writes during INIT: 3 edges after reset, wr_en_i=1, addr 3, data 0xAA -> ignored; r3 reads 0 once ready_o=1.
- Mid-operation reset: write 0x55 to r9 in RUN, assert rst_i -> ready_o drops to 0 immediately; after the 32-cycle re-clear, r9 reads 0.
- Scoreboard (RF_SCOREBOARD_EN):
  - reserve r4 -> rd_pend_o[0]=1 for addr 4.
  - Same-edge reserve r4 and write r4 -> bit stays 1.
  - A later write of 0x99 to r4 without reserve -> rd_pend_o[0]=0 in that cycle, with data forwarded as 0x99.
